// File: rtl/axis_framer.sv
// AXI4-Stream framer: prefixes every PKT_LEN payload beats with a header word
// carrying a marker byte, the packet length and a wrapping sequence number.
module axis_framer #(
    parameter int WIRE_WIDTH = 32,
    parameter int PKT_LEN    = 16,
    parameter int SEQ_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  resetn,

    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [WIRE_WIDTH-1:0] in_data_i,

    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [WIRE_WIDTH-1:0] out_data_o,

    input  logic                  enable_i,
    output logic [SEQ_WIDTH-1:0]  seq_o,
    output logic                  busy_o
);

    localparam logic [7:0] PKT_LEN8  = 8'(PKT_LEN);
    localparam logic [7:0] LAST_BEAT = 8'(PKT_LEN - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        PAYLOAD = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic                    outValid_q, outValid_d;
    logic [WIRE_WIDTH-1:0]   outData_q, outData_d;
    logic [7:0]              beatCnt_q, beatCnt_d;
    logic [SEQ_WIDTH-1:0]    seq_q, seq_d;
    logic                    started_q;

    logic                    slotFree;
    logic                    payloadXfer;
    logic [WIRE_WIDTH-1:0]   headerWord;

    assign slotFree    = !outValid_q || out_ready_i;
    assign in_ready_o  = (state_q == PAYLOAD) && slotFree;
    assign payloadXfer = in_valid_i && in_ready_o;

    assign out_valid_o = outValid_q;
    assign out_data_o  = outData_q;
    assign seq_o       = seq_q;
    assign busy_o      = (state_q == PAYLOAD);

    always_comb begin
        headerWord        = '0;
        headerWord[31:24] = 8'hA5;
        headerWord[23:16] = PKT_LEN8;
        headerWord[15:0]  = 16'(seq_q);
    end

    always_comb begin
        state_d    = state_q;
        outValid_d = outValid_q;
        outData_d  = outData_q;
        beatCnt_d  = beatCnt_q;
        seq_d      = seq_q;

        // A beat leaving the slot with nothing new behind it empties the slot.
        if (slotFree) begin
            outValid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (started_q && enable_i && in_valid_i && slotFree) begin
                    outData_d  = headerWord;
                    outValid_d = 1'b1;
                    beatCnt_d  = 8'd0;
                    state_d    = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (payloadXfer) begin
                    outData_d  = in_data_i;
                    outValid_d = 1'b1;
                    beatCnt_d  = beatCnt_q + 8'd1;
                    if (beatCnt_q == LAST_BEAT) begin
                        state_d = IDLE;
                        seq_d   = seq_q + SEQ_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Holds off the first header for one full cycle after reset release.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            started_q <= 1'b0;
        end else begin
            started_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            outValid_q <= 1'b0;
            outData_q  <= '0;
            beatCnt_q  <= 8'd0;
            seq_q      <= '0;
        end else begin
            state_q    <= state_d;
            outValid_q <= outValid_d;
            outData_q  <= outData_d;
            beatCnt_q  <= beatCnt_d;
            seq_q      <= seq_d;
        end
    end

endmodule

// File: tb/tb_axis_framer.sv
// Bench for axis_framer: directed steps plus a random phase, with every output
// beat checked against a queue of expected header/payload words.
module tb_axis_framer;

    localparam int WW = 40;
    localparam int PL = 4;
    localparam int SW = 4;

    logic          clk;
    logic          resetn;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [WW-1:0] in_data_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [WW-1:0] out_data_o;
    logic          enable_i;
    logic [SW-1:0] seq_o;
    logic          busy_o;

    int            total    = 0;
    int            bad      = 0;
    int            cyc      = 0;
    int            xferCnt  = 0;
    int            firstCyc = -1;
    int            lastCyc  = 0;
    int            seqModel = 0;
    int            markCnt  = 0;
    logic          monOn    = 1'b0;
    logic [WW-1:0] dataNext = 1;
    logic [WW-1:0] expBeat;
    logic [WW-1:0] sbQ[$];

    axis_framer #(
        .WIRE_WIDTH (WW),
        .PKT_LEN    (PL),
        .SEQ_WIDTH  (SW)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .enable_i    (enable_i),
        .seq_o       (seq_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WW-1:0] hdr(input int s);
        logic [WW-1:0] h;
        h        = '0;
        h[31:24] = 8'hA5;
        h[23:16] = 8'(PL);
        h[15:0]  = 16'(s);
        return h;
    endfunction

    // Output-side scoreboard: every accepted output beat pops one expectation.
    always @(negedge clk) begin
        if (monOn && resetn && out_valid_o && out_ready_i) begin
            if (sbQ.size() == 0) begin
                checkOutput("sb_extra_beat", 64'(sbQ.size()), 64'd1);
            end else begin
                expBeat = sbQ.pop_front();
                checkOutput("sb_beat", 64'(out_data_o), 64'(expBeat));
            end
            xferCnt++;
            if (firstCyc < 0) firstCyc = cyc;
            lastCyc = cyc;
        end
    end

    task automatic sendBeat(input logic [WW-1:0] d, input int vPct, input int rPct);
        bit acc;
        bit done;
        done        = 1'b0;
        in_data_i   = d;
        in_valid_i  = (int'($urandom_range(99)) < vPct);
        out_ready_i = (int'($urandom_range(99)) < rPct);
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            acc = in_valid_i && in_ready_o;
            @(posedge clk);
            #1;
            if (acc) begin
                done = 1'b1;
            end else begin
                in_valid_i  = (int'($urandom_range(99)) < vPct);
                out_ready_i = (int'($urandom_range(99)) < rPct);
            end
        end
        checkOutput("beat_accept", 64'(done), 64'd1);
    endtask

    task automatic pushPacket(output logic [WW-1:0] d[PL], input bit randData);
        for (int i = 0; i < PL; i++) begin
            if (randData) begin
                d[i] = WW'({$urandom(), $urandom()});
            end else begin
                d[i]     = dataNext;
                dataNext = dataNext + 1;
            end
        end
        sbQ.push_back(hdr(seqModel));
        seqModel = (seqModel + 1) % (1 << SW);
        for (int i = 0; i < PL; i++) sbQ.push_back(d[i]);
    endtask

    task automatic applyStimulus(input int nPkts, input int vPct, input int rPct, input bit randData);
        logic [WW-1:0] d[PL];
        for (int p = 0; p < nPkts; p++) begin
            pushPacket(d, randData);
            for (int i = 0; i < PL; i++) sendBeat(d[i], vPct, rPct);
        end
    endtask

    task automatic drain();
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        for (int c = 0; c < 100 && sbQ.size() != 0; c++) begin
            @(posedge clk);
            #1;
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        checkOutput("sb_drain", 64'(sbQ.size()), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [WW-1:0] d[PL];

        resetn      = 1'b0;
        enable_i    = 1'b0;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        out_ready_i = 1'b1;
        #12;
        checkOutput("rst_out_valid", 64'(out_valid_o), 64'd0);
        checkOutput("rst_out_data",  64'(out_data_o),  64'd0);
        checkOutput("rst_seq",       64'(seq_o),       64'd0);
        checkOutput("rst_busy",      64'(busy_o),      64'd0);
        checkOutput("rst_in_ready",  64'(in_ready_o),  64'd0);

        $display("[TB] release reset, header must wait for the second edge");
        enable_i    = 1'b1;
        in_valid_i  = 1'b1;
        in_data_i   = dataNext;
        out_ready_i = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        monOn  = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("no_hdr_edge1", 64'(out_valid_o), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("hdr_valid_edge2", 64'(out_valid_o), 64'd1);
        checkOutput("hdr_data_edge2",  64'(out_data_o),  64'(hdr(0)));
        checkOutput("hdr_busy",        64'(busy_o),      64'd1);
        checkOutput("hdr_in_ready",    64'(in_ready_o),  64'd0);

        $display("[TB] back-to-back packets with no bubbles");
        firstCyc = -1;
        markCnt  = xferCnt;
        applyStimulus(3, 100, 100, 1'b0);
        drain();
        checkOutput("b2b_beats", 64'(xferCnt - markCnt), 64'(3 * (PL + 1)));
        checkOutput("b2b_span",  64'(lastCyc - firstCyc), 64'(3 * (PL + 1) - 1));
        checkOutput("seq_after3", 64'(seq_o), 64'd3);

        $display("[TB] downstream stall on a payload beat");
        pushPacket(d, 1'b0);
        sendBeat(d[0], 100, 100);
        sendBeat(d[1], 100, 100);
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = d[2];
        repeat (3) begin
            @(negedge clk);
            checkOutput("stall_valid",    64'(out_valid_o), 64'd1);
            checkOutput("stall_data",     64'(out_data_o),  64'(d[1]));
            checkOutput("stall_in_ready", 64'(in_ready_o),  64'd0);
            @(posedge clk);
            #1;
        end
        sendBeat(d[2], 100, 100);
        sendBeat(d[3], 100, 100);
        drain();

        $display("[TB] enable dropped inside packet seq 7");
        applyStimulus(3, 100, 100, 1'b0);
        drain();
        pushPacket(d, 1'b0);
        in_valid_i  = 1'b1;
        in_data_i   = d[0];
        out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("hdr7_busy", 64'(busy_o), 64'd1);
        enable_i = 1'b0;
        for (int i = 0; i < PL; i++) sendBeat(d[i], 100, 100);
        in_valid_i = 1'b1;
        in_data_i  = dataNext;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        checkOutput("noen_busy",     64'(busy_o),      64'd0);
        checkOutput("noen_seq",      64'(seq_o),       64'd8);
        checkOutput("noen_valid",    64'(out_valid_o), 64'd0);
        checkOutput("noen_in_ready", 64'(in_ready_o),  64'd0);
        checkOutput("noen_sb_empty", 64'(sbQ.size()),  64'd0);
        enable_i = 1'b1;
        drain();

        $display("[TB] reset in the middle of a packet");
        pushPacket(d, 1'b0);
        sendBeat(d[0], 100, 100);
        sendBeat(d[1], 100, 100);
        resetn = 1'b0;
        #1;
        checkOutput("midrst_valid",    64'(out_valid_o), 64'd0);
        checkOutput("midrst_data",     64'(out_data_o),  64'd0);
        checkOutput("midrst_busy",     64'(busy_o),      64'd0);
        checkOutput("midrst_seq",      64'(seq_o),       64'd0);
        checkOutput("midrst_in_ready", 64'(in_ready_o),  64'd0);
        sbQ.delete();
        seqModel = 0;
        @(negedge clk);
        @(negedge clk);
        in_valid_i  = 1'b1;
        out_ready_i = 1'b1;
        resetn      = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst_no_hdr_edge1", 64'(out_valid_o), 64'd0);
        applyStimulus(1, 100, 100, 1'b0);
        drain();

        $display("[TB] random valid/ready, 1000 packets");
        applyStimulus(1000, 50, 50, 1'b1);
        drain();
        checkOutput("seq_final",  64'(seq_o),  64'(seqModel));
        checkOutput("idle_final", 64'(busy_o), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_framer.md
AXIS_FRAMER -- requirements
Module: axis_framer

Interface
REQ-001 Parameter WIRE_WIDTH, default 32, beat width in bits; SHALL be >= 32.
REQ-002 Parameter PKT_LEN, default 16, payload beats per packet; SHALL be in range 1..255.
REQ-003 Parameter SEQ_WIDTH, default 16, sequence counter width; SHALL be in range 1..16.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 resetn  input  1  asynchronous, active-low reset; asserting it clears all state immediately.
REQ-006 in  AXI4S.Slave  WIRE_WIDTH  payload stream: in.valid, in.ready, in.data.
REQ-007 out  AXI4S.Master  WIRE_WIDTH  framed stream to the downstream AXISFIFO: out.valid, out.ready, out.data.
REQ-008 enable  input  1  high to start new packets; low stops framing at the next packet boundary.
REQ-009 seq  output  SEQ_WIDTH  sequence number of the current or next packet.
REQ-010 busy  output  1  high while a packet is in progress (state PAYLOAD).

Function
REQ-011 The block SHALL have two states: IDLE (no packet open) and PAYLOAD (payload beats being passed).
REQ-012 Output register: out.valid and out.data SHALL be registered; out.data SHALL stay constant while out.valid=1 and out.ready=0.
REQ-013 The output slot SHALL be free when out.valid=0 or out.ready=1.
REQ-014 Header word: [31:24]=8'hA5, [23:16]=PKT_LEN[7:0], [15:0]=seq zero-extended; bits above 31 SHALL be 0.
REQ-015 IDLE -> PAYLOAD: when enable=1, in.valid=1 and the slot is free, the header SHALL be loaded into out.data, out.valid set to 1, beat counter cleared, state PAYLOAD.
REQ-016 No input beat SHALL be consumed in the header cycle; in.ready=0 throughout IDLE.
REQ-017 in.ready SHALL equal (state==PAYLOAD) & slot free, combinationally.
REQ-018 Payload transfer (in.valid & in.ready): in.data SHALL be loaded into out.data, out.valid=1, beat counter +1.
REQ-019 On the PKT_LEN-th payload transfer, the block SHALL go to IDLE and increment seq, wrapping from 2^SEQ_WIDTH-1 to 0.
REQ-020 Slot free and no new load: out.valid SHALL go to 0.
REQ-021 Throughput: a back-to-back packet with in.valid=1 and out.ready=1 SHALL take PKT_LEN+1 cycles, one output beat per cycle. The next header SHALL load in the cycle after the last payload transfer.
REQ-022 Simultaneous events: downstream accept and new load in the same cycle SHALL keep out.valid=1 with no gap and no lost or duplicated beat.
REQ-023 enable is sampled only in IDLE; deasserting it in PAYLOAD SHALL NOT truncate the packet.
REQ-024 PKT_LEN=1: each packet SHALL be exactly header + one payload beat.
REQ-025 Beat counter width SHALL be 8 bits and SHALL not overflow for legal PKT_LEN.
REQ-026 busy SHALL be 1 exactly when state==PAYLOAD.

Reset
REQ-027 resetn=0 SHALL force, asynchronously: state IDLE, out.valid=0, out.data=0, seq=0, beat counter=0, busy=0, in.ready=0.
REQ-028 Reset asserted mid-packet SHALL discard the partial packet. After release, the first output SHALL be a header with seq=0.
REQ-029 After resetn rises, the first header SHALL NOT appear before the second rising clk edge.

Verification
REQ-030 PKT_LEN=4, enable=1, in.valid=1 with data 1,2,3,4,5..., out.ready=1 -> out: 0xA5040000,1,2,3,4,0xA5040001,5,... with no bubbles.
REQ-031 out.ready=0 for 3 cycles during a payload beat holding data 2 -> out.data=2 and out.valid=1 held stable; in.ready=0 for those cycles; beat order intact afterwards.
REQ-032 enable dropped after the header of packet seq=7 -> all PKT_LEN payload beats complete; block stays IDLE, busy=0, seq=8.
REQ-033 SEQ_WIDTH=2, run 5 packets -> header seq fields 0,1,2,3,0.
REQ-034 resetn pulsed low after 2 of 4 payload beats -> out.valid=0 immediately; next output after release is 0xA5040000.
REQ-035 Random in.valid and out.ready (50%), 1000 packets -> scoreboard matches header+payload sequence exactly; no beat lost or duplicated.
